// File: rtl/servo_pkg.sv
// Shared definitions for the servo readback transmitter.
//   DEF_DATA_W : default bits per channel byte
//   HDR_TAG    : upper-nibble tag of the optional frame header byte
//   state_t    : transmitter state encoding
//   clog2      : ceiling log2 for sizing counters
package servo_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam logic [7:0]  HDR_TAG    = 8'hA0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Smallest r with 2**r >= v; 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(v)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, plus one extra flop for
// edge detection. Pin events appear on rise_c/fall_c STAGES+1 clocks later
// as seen by a downstream register.
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous pin
//   level    : synchronised pin level
//   rise_c   : one-clk pulse on a synchronised rising edge (combinational)
//   fall_c   : one-clk pulse on a synchronised falling edge (combinational)
module servo_sync_edge #(
    parameter int unsigned STAGES   = 2,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser chain and edge-detect history, reset to the pin idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level  = sync_q[STAGES-1];
    assign rise_c = sync_q[STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/servo_spi_readback_tx.sv
// SPI-slave (mode 0) MISO transmitter for servo position readback.
// On cs_n falling edge all channel bytes are snapshotted and then shifted
// out MSB-first, channel 0 first, one bit per sck falling edge.
// Optional macro SERVO_READBACK_HEADER_EN prepends a header byte
// {4'hA, NUM_CH[3:0]} ahead of channel 0.
//   clk, rst   : system clock (>= 8x sck), synchronous active-high reset
//   sck, cs_n  : asynchronous SPI clock / chip select from master
//   ch_data    : flattened channel bytes, channel k at [k*DATA_W +: DATA_W]
//   miso       : serial data to master
//   miso_oe    : pad output enable, high while selected
//   busy       : high from frame start until cs_n deassert
//   frame_done : one-clk pulse when the final frame bit is sampled
//   abort      : one-clk pulse when cs_n rises before frame completion
module servo_spi_readback_tx
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sck,
    input  logic                     cs_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic                     miso,
    output logic                     miso_oe,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     abort
);

`ifdef SERVO_READBACK_HEADER_EN
    localparam int unsigned HDR_BYTES = 1;
`else
    localparam int unsigned HDR_BYTES = 0;
`endif
    localparam int unsigned FRAME_BYTES = NUM_CH + HDR_BYTES;
    localparam int unsigned FRAME_BITS  = FRAME_BYTES * DATA_W;
    localparam int unsigned BYTE_W      = clog2(FRAME_BYTES + 1);
    localparam int unsigned BIT_W       = (DATA_W > 1) ? clog2(DATA_W) : 1;
    localparam int unsigned CNT_W       = clog2(FRAME_BITS + 1);
    localparam int unsigned POS_W       = (FRAME_BITS > 1) ? clog2(FRAME_BITS) : 1;
    localparam int unsigned SETTLE      = SYNC_STAGES + 1;
    localparam int unsigned SET_W       = clog2(SETTLE + 1);

    logic sck_level_unused;
    logic sck_rise, sck_fall;
    logic cs_level, cs_rise, cs_fall;

    servo_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_sck (
        .clk    (clk),
        .rst    (rst),
        .din    (sck),
        .level  (sck_level_unused),
        .rise_c (sck_rise),
        .fall_c (sck_fall)
    );

    servo_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .din    (cs_n),
        .level  (cs_level),
        .rise_c (cs_rise),
        .fall_c (cs_fall)
    );

    // Frame image: byte j of the frame lives at [j*DATA_W +: DATA_W].
    logic [FRAME_BITS-1:0] snap_c;
    logic [FRAME_BITS-1:0] shadow;
`ifdef SERVO_READBACK_HEADER_EN
    logic [DATA_W-1:0] header_c;
    assign header_c = DATA_W'(HDR_TAG | 8'(NUM_CH % 16));
    assign snap_c   = {ch_data, header_c};
`else
    assign snap_c   = ch_data;
`endif

    state_t            state;
    logic [BYTE_W-1:0] byte_idx, nxt_byte;
    logic [BIT_W-1:0]  bit_idx, nxt_bit;
    logic [CNT_W-1:0]  rise_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic              armed;
    logic [31:0]       pos_full;
    logic              nxt_miso;

    // Next bit position after an sck falling edge; past the last byte drives 0.
    always_comb begin
        nxt_bit  = bit_idx - BIT_W'(1);
        nxt_byte = byte_idx;
        if (bit_idx == '0) begin
            nxt_bit  = BIT_W'(DATA_W - 1);
            nxt_byte = byte_idx + BYTE_W'(1);
        end
        pos_full = 32'(nxt_byte) * 32'(DATA_W) + 32'(nxt_bit);
        nxt_miso = (nxt_byte < BYTE_W'(FRAME_BYTES)) ? shadow[POS_W'(pos_full)] : 1'b0;
    end

    // Shadow is pure datapath, loaded only at frame start.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && armed && cs_fall) begin
            shadow <= snap_c;
        end
    end

    // A frame may only start after cs_n has been seen high since reset, so a
    // pin left low across reset cannot masquerade as a fresh select.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else if (settle_cnt != SET_W'(SETTLE)) begin
            settle_cnt <= settle_cnt + SET_W'(1);
        end else if (cs_level) begin
            armed <= 1'b1;
        end
    end

    // Transmitter FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_idx   <= '0;
            bit_idx    <= '0;
            rise_cnt   <= '0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            abort      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            abort      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (armed && cs_fall) begin
                        byte_idx <= '0;
                        bit_idx  <= BIT_W'(DATA_W - 1);
                        rise_cnt <= '0;
                        miso     <= snap_c[DATA_W-1];
                        miso_oe  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        miso    <= 1'b0;
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        abort   <= 1'b1;
                        state   <= ST_IDLE;
                    end else if (sck_rise) begin
                        rise_cnt <= rise_cnt + CNT_W'(1);
                        if (rise_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            frame_done <= 1'b1;
                            miso       <= 1'b0;
                            state      <= ST_DONE;
                        end
                    end else if (sck_fall) begin
                        bit_idx  <= nxt_bit;
                        byte_idx <= nxt_byte;
                        miso     <= nxt_miso;
                    end
                end
                ST_DONE: begin
                    miso <= 1'b0;
                    if (cs_rise) begin
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_servo_spi_readback_tx.sv
// Directed self-checking bench for servo_spi_readback_tx (NUM_CH=8, DATA_W=8).
// Acts as an SPI mode-0 master with sck at clk/16.
module tb_servo_spi_readback_tx;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned DATA_W = 8;
`ifdef SERVO_READBACK_HEADER_EN
    localparam int FB = NUM_CH + 1;
`else
    localparam int FB = NUM_CH;
`endif
    localparam int FBITS = FB * 8;
    localparam logic [63:0] CH_INIT = 64'h8776_6554_4332_2110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        cs_n = 1'b1;
    logic [63:0] ch_data = CH_INIT;
    logic        miso, miso_oe, busy, frame_done, abort;

    int n_cmp = 0;
    int n_bad = 0;
    int fd_cnt = 0;
    int ab_cnt = 0;
    int fd_base, ab_base, fd_pre;
    logic [7:0] rx_b  [0:15];
    logic [7:0] exp_b [0:15];

    servo_spi_readback_tx #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sck        (sck),
        .cs_n       (cs_n),
        .ch_data    (ch_data),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .busy       (busy),
        .frame_done (frame_done),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (abort)      ab_cnt <= ab_cnt + 1;
    end

    // Select, then clock n_cyc bits; master samples miso just before each rise.
    task automatic run_frame(input int n_cyc, input int chg_at);
        for (int i = 0; i < 16; i++) rx_b[i] = 8'h00;
        fd_pre = -1;
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < n_cyc; i++) begin
            if (i == chg_at) ch_data = '1;
            if (i == FBITS - 1) fd_pre = fd_cnt - fd_base;
            rx_b[i/8] = {rx_b[i/8][6:0], miso};
            sck = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_bytes(input string tag);
        for (int i = 0; i < FB; i++) begin
            n_cmp++;
            if (rx_b[i] !== exp_b[i]) begin
                n_bad++;
                $display("FAIL %s byte%0d: got %h expected %h", tag, i, rx_b[i], exp_b[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({miso, miso_oe, busy, frame_done, abort} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 00000",
                     {miso, miso_oe, busy, frame_done, abort});
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++;
        if ({miso_oe, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b expected 00", {miso_oe, busy});
        end
    endtask

    task automatic test_full_frame();
        fd_base = fd_cnt; ab_base = ab_cnt;
        run_frame(FBITS, -1);
        n_cmp++;
        if ({miso_oe, busy} !== 2'b11) begin
            n_bad++;
            $display("FAIL full_done_state: got oe/busy %b expected 11", {miso_oe, busy});
        end
        n_cmp++;
        if (fd_pre !== 0) begin
            n_bad++;
            $display("FAIL full_early_done: got %0d expected 0", fd_pre);
        end
        end_frame();
        check_bytes("full");
        n_cmp++;
        if (fd_cnt - fd_base !== 1) begin
            n_bad++;
            $display("FAIL full_done_count: got %0d expected 1", fd_cnt - fd_base);
        end
        n_cmp++;
        if (ab_cnt - ab_base !== 0) begin
            n_bad++;
            $display("FAIL full_abort: got %0d expected 0", ab_cnt - ab_base);
        end
        n_cmp++;
        if ({miso_oe, busy, miso} !== 3'b000) begin
            n_bad++;
            $display("FAIL full_release: got %b expected 000", {miso_oe, busy, miso});
        end
    endtask

    task automatic test_snapshot_hold();
        fd_base = fd_cnt;
        run_frame(FBITS, 10);
        end_frame();
        ch_data = CH_INIT;
        check_bytes("snapshot");
        n_cmp++;
        if (fd_cnt - fd_base !== 1) begin
            n_bad++;
            $display("FAIL snapshot_done_count: got %0d expected 1", fd_cnt - fd_base);
        end
    endtask

    task automatic test_abort();
        fd_base = fd_cnt; ab_base = ab_cnt;
        run_frame(20, -1);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (miso_oe !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_early_oe: got %b expected 1", miso_oe);
        end
        @(negedge clk);
        n_cmp++;
        if ({abort, miso_oe, busy} !== 3'b100) begin
            n_bad++;
            $display("FAIL abort_edge: got abort/oe/busy %b expected 100", {abort, miso_oe, busy});
        end
        @(negedge clk);
        n_cmp++;
        if (abort !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_width: got %b expected 0", abort);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (ab_cnt - ab_base !== 1 || fd_cnt - fd_base !== 0) begin
            n_bad++;
            $display("FAIL abort_counts: got abort %0d done %0d expected 1 0",
                     ab_cnt - ab_base, fd_cnt - fd_base);
        end
    endtask

    task automatic test_overclock();
        fd_base = fd_cnt; ab_base = ab_cnt;
        run_frame(FBITS + 8, -1);
        end_frame();
        check_bytes("overclock");
        n_cmp++;
        if (rx_b[FB] !== 8'h00) begin
            n_bad++;
            $display("FAIL overclock_filler: got %h expected 00", rx_b[FB]);
        end
        n_cmp++;
        if (fd_cnt - fd_base !== 1 || ab_cnt - ab_base !== 0) begin
            n_bad++;
            $display("FAIL overclock_pulses: got done %0d abort %0d expected 1 0",
                     fd_cnt - fd_base, ab_cnt - ab_base);
        end
    endtask

    task automatic test_reset_midframe();
        fd_base = fd_cnt; ab_base = ab_cnt;
        run_frame(30, -1);
        sck = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({miso, miso_oe, busy, frame_done, abort} !== 5'b00000) begin
            n_bad++;
            $display("FAIL midreset_outputs: got %b expected 00000",
                     {miso, miso_oe, busy, frame_done, abort});
        end
        rst = 1'b0;
        sck = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if ({miso_oe, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL midreset_stale_cs: got %b expected 00", {miso_oe, busy});
        end
        end_frame();
        fd_base = fd_cnt; ab_base = ab_cnt;
        run_frame(FBITS, -1);
        end_frame();
        check_bytes("after_reset");
        n_cmp++;
        if (fd_cnt - fd_base !== 1 || ab_cnt - ab_base !== 0) begin
            n_bad++;
            $display("FAIL after_reset_pulses: got done %0d abort %0d expected 1 0",
                     fd_cnt - fd_base, ab_cnt - ab_base);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) exp_b[i] = 8'h00;
`ifdef SERVO_READBACK_HEADER_EN
        exp_b[0] = 8'hA8;
        for (int i = 0; i < NUM_CH; i++) exp_b[i+1] = CH_INIT[i*8 +: 8];
`else
        for (int i = 0; i < NUM_CH; i++) exp_b[i] = CH_INIT[i*8 +: 8];
`endif
        test_reset();
        test_full_frame();
        test_snapshot_hold();
        test_abort();
        test_overclock();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/servo_spi_readback_tx.md
Name: servo_spi_readback_tx

Overview:
- SPI-slave MISO transmitter for the servo controller's readback path. The master reads back the current servo position bytes.
- On chip-select assertion it snapshots all channel position bytes, then serialises them MSB-first, channel 0 first, in SPI mode 0.
- It is the outbound counterpart of the inbound byte shift register that feeds the servo taps. It runs entirely in the system clock domain, with synchronised SCK and CS_n.

Parameters:
- NUM_CH, 8, number of servo channel bytes per frame (1..64).
- DATA_W, 8, bits per channel byte.
- SYNC_STAGES, 2, flip-flop stages on sck and cs_n (at least 2).

Ports:
- clk  in  1  system clock. Must be at least 8x the SCK frequency.
- rst  in  1  synchronous, active-high reset.
- sck  in  1  SPI clock from master (asynchronous). Idles low.
- cs_n  in  1  SPI chip select, active low (asynchronous).
- ch_data  in  NUM_CH*DATA_W  flattened channel bytes; channel k occupies [k*DATA_W +: DATA_W].
- miso  out  1  serial data to master.
- miso_oe  out  1  output enable for the MISO pad tristate. High only while selected.
- busy  out  1  high from frame start until cs_n deassert.
- frame_done  out  1  one-clk pulse when the final bit of the final byte is sampled.
- abort  out  1  one-clk pulse when cs_n rises before frame completion.

Behaviour:
- Reset values (rst=1 at a clk edge): miso=0, miso_oe=0, busy=0, frame_done=0, abort=0. State=IDLE, counters=0, synchronisers=idle (sck=0, cs_n=1).
- sck and cs_n each pass through SYNC_STAGES flops. A further flop provides edge detection. Every pin-level event is therefore seen SYNC_STAGES+1 clk later.
- IDLE:
  - On cs_n falling edge: snapshot ch_data into the internal shadow, set byte_idx=0 and bit_idx=DATA_W-1.
  - Drive miso=snapshot byte 0 MSB, set miso_oe=1, busy=1, then go to SHIFT.
  - The first bit is valid before the first sck rising edge.
- SHIFT:
  - sck rising edge: the master samples. Increment the rising-edge count. When the count reaches NUM_CH*DATA_W, pulse frame_done and go to DONE.
  - sck falling edge: advance bit_idx. When bit_idx wraps past 0, reload to DATA_W-1 and increment byte_idx. Drive miso from snapshot[byte_idx][bit_idx].
  - Simultaneous rise and fall in one clk cannot occur at a legal clk:sck ratio. If it does, the rise is processed first.
- DONE: miso=0, oe stays 1, busy stays 1. Any further sck edges drive 0 filler. No wrap back to channel 0.
- cs_n rising edge (any state other than IDLE):
  - Go to IDLE with miso_oe=0, busy=0, miso=0.
  - If the state was SHIFT, pulse abort; frame_done is not pulsed.
  - If the state was DONE, no pulse.
- cs_n falling edge while not in IDLE cannot occur, because a rising edge always intervenes.
- The snapshot is taken only at frame start. Changes to ch_data mid-frame have no effect on the frame.
- A reset mid-frame forces the reset values immediately, regardless of the pins. A new frame starts only on a fresh cs_n falling edge observed after reset.
- Counter widths: byte_idx uses clog2(NUM_CH+1) bits, bit_idx uses clog2(DATA_W) bits.

Optional Feature:
- Macro: SERVO_READBACK_HEADER_EN.
- When defined:
  - A header byte is prepended before channel 0. Its upper nibble is 4'hA and its lower nibble is NUM_CH[3:0].
  - The frame length becomes (NUM_CH+1)*DATA_W bits, and frame_done moves accordingly.
  - The header is part of the snapshot shadow.
- When undefined: the frame is the channel bytes only, and no header logic or storage exists.

Decomposition:
- Shared package servo_pkg: DATA_W default, the header constant 8'hA0, state encoding (IDLE, SHIFT, DONE), and a clog2 function.
- One natural sub-module: servo_sync_edge, a SYNC_STAGES synchroniser with rise/fall pulse outputs. It is instantiated for both sck and cs_n.

Test Plan:
- Full frame:
  - Stimulus: reset; ch_data bytes = 8'h10,8'h21,...,8'h87 for channels 0..7; cs_n low; 64 sck cycles at clk/16; cs_n high.
  - Required response: master receives 0x10,0x21,...,0x87 MSB-first; frame_done pulses once after the 64th rise; abort stays 0.
- Snapshot hold: change ch_data to all 8'hFF after 10 sck cycles -> received bytes still equal the original values.
- Abort: raise cs_n after 20 sck cycles -> abort pulses 1 clk; miso_oe=0 and busy=0 within SYNC_STAGES+1 clk; no frame_done.
- Overclock filler: 72 sck cycles -> bytes 0..7 correct, then 0x00; single frame_done.
- Reset mid-frame: assert rst during bit 30 with cs_n still low -> all outputs are at reset values next clk. After cs_n high and then low again, a clean frame starting at channel 0 is received.
- With SERVO_READBACK_HEADER_EN: NUM_CH=8 -> first byte 0xA8, then 8 channel bytes; frame_done after 72 rises.
